// File: rtl/reg_scoreboard_if.sv
// ID-stage bundle between the decode stage and the issue scoreboard.
// The decode side presents the instruction; the scoreboard answers with stall/issue.
interface reg_scoreboard_if #(
  parameter int REG_W = 3
);
  logic             id_valid;
  logic [3:0]       opcode_id;
  logic [REG_W-1:0] src_1;
  logic [REG_W-1:0] src_2;
  logic [REG_W-1:0] dest_id;
  logic             flush;
  logic             stall;
  logic             issue;

  modport master (
    output id_valid, opcode_id, src_1, src_2, dest_id, flush,
    input  stall, issue
  );

  modport slave (
    input  id_valid, opcode_id, src_1, src_2, dest_id, flush,
    output stall, issue
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Issue-stage scoreboard: per-register write countdowns gate ID->EX issue,
// with drain/halt sequencing and a saturating stall-cycle counter.
module reg_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int ALU_LAT  = 3,
  parameter int LD_LAT   = 4,
  parameter int CNT_W    = 3,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  reg_scoreboard_if.slave     id_bus,
  input  logic                drain_req,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                idle,
  output logic [STALL_W-1:0]  stall_cycles
);

  localparam logic [3:0]       OP_NOP  = 4'd0;
  localparam logic [3:0]       OP_LD   = 4'd10;
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LD_CNT  = CNT_W'(LD_LAT);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic                 idle_reg;
  logic                 idle_next;
  logic [STALL_W-1:0]   stall_cnt_reg;
  logic [NUM_REGS-1:0]  busy_vec;

  logic is_writer;
  logic is_ld;
  logic hazard;
  logic stall_int;
  logic issue_int;
  logic load_en;

  assign is_writer = (id_bus.opcode_id != OP_NOP) && (id_bus.opcode_id <= OP_LD);
  assign is_ld     = (id_bus.opcode_id == OP_LD);

  // r0 is hardwired zero, so it never gets a counter and never reads as busy.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign busy_vec[gi] = 1'b0;
      end else begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            cnt_reg <= '0;
          end else if (load_en && (id_bus.dest_id == REG_W'(gi))) begin
            cnt_reg <= is_ld ? LD_CNT : ALU_CNT;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        assign busy_vec[gi] = (cnt_reg != '0);
      end
    end
  endgenerate

  always_comb begin
    hazard = 1'b0;
    if (id_bus.id_valid && (id_bus.opcode_id != OP_NOP)) begin
      if ((id_bus.src_1 != '0) && busy_vec[id_bus.src_1])
        hazard = 1'b1;
      if ((id_bus.src_2 != '0) && busy_vec[id_bus.src_2])
        hazard = 1'b1;
      if (is_writer && (id_bus.dest_id != '0) && busy_vec[id_bus.dest_id])
        hazard = 1'b1;
    end
  end

  // A flushed instruction is dead: it neither stalls nor issues.
  always_comb begin
    stall_int = (hazard || (state_reg != ST_RUN)) && id_bus.id_valid && !id_bus.flush;
    issue_int = id_bus.id_valid && !id_bus.flush && !stall_int && (state_reg == ST_RUN);
    load_en   = issue_int && is_writer && (id_bus.dest_id != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RUN;
      idle_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idle_reg  <= idle_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idle_next  = idle_reg;
    case (state_reg)
      ST_RUN: begin
        idle_next = 1'b0;
        if (drain_req)
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req) begin
          state_next = ST_RUN;
          idle_next  = 1'b0;
        end else if (busy_vec == '0) begin
          state_next = ST_HALT;
          idle_next  = 1'b1;
        end
      end
      ST_HALT: begin
        if (!drain_req) begin
          state_next = ST_RUN;
          idle_next  = 1'b0;
        end else begin
          idle_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
        idle_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_int && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign id_bus.stall = stall_int;
  assign id_bus.issue = issue_int;
  assign busy_mask    = busy_vec;
  assign idle         = idle_reg;
  assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized scoreboard bench for reg_scoreboard: a cycle-level reference model
// tracks when each register becomes readable and queues the expected outputs.
module tb_reg_scoreboard;

  localparam int ALU_LAT = 3;
  localparam int LD_LAT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        drain_req;
  logic [7:0]  busy_mask;
  logic        idle;
  logic [15:0] stall_cycles;

  reg_scoreboard_if #(.REG_W(3)) bus ();

  reg_scoreboard #(
    .NUM_REGS(8), .REG_W(3), .ALU_LAT(ALU_LAT), .LD_LAT(LD_LAT),
    .CNT_W(3), .STALL_W(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_bus      (bus.slave),
    .drain_req   (drain_req),
    .busy_mask   (busy_mask),
    .idle        (idle),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        issue;
    logic [7:0]  busy;
    logic        idle;
    logic [15:0] sc;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference model: cycle number from which each register is readable again.
  int ready_at[8];
  int cyc;
  int mode;          // 0 running, 1 draining, 2 halted
  bit idle_m;
  int sc_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) ready_at[r] = 0;
    mode   = 0;
    idle_m = 1'b0;
    sc_m   = 0;
  endtask

  function automatic bit reg_busy(input int r);
    return (r != 0) && (cyc < ready_at[r]);
  endfunction

  task automatic do_cycle(input bit v, input int op, input int s1, input int s2,
                          input int d, input bit fl, input bit dr, output bit iss);
    exp_t e;
    bit   wr;
    bit   hz;
    bit   st;
    bit   any_busy;
    logic [7:0] bm;
    @(posedge clk);
    #1;
    bus.id_valid  = v;
    bus.opcode_id = 4'(op);
    bus.src_1     = 3'(s1);
    bus.src_2     = 3'(s2);
    bus.dest_id   = 3'(d);
    bus.flush     = fl;
    drain_req     = dr;

    bm = '0;
    for (int r = 0; r < 8; r++) bm[r] = reg_busy(r);
    any_busy = (bm != 0);
    wr  = (op >= 1) && (op <= 10);
    hz  = v && (op != 0) && ((s1 != 0 && bm[s1]) || (s2 != 0 && bm[s2]) ||
                             (wr && d != 0 && bm[d]));
    st  = (hz || mode != 0) && v && !fl;
    iss = v && !fl && !st && (mode == 0);

    e.stall = st;
    e.issue = iss;
    e.busy  = bm;
    e.idle  = idle_m;
    e.sc    = 16'(sc_m);
    e.cyc   = cyc;
    sb.push_back(e);
    if (iss)
      $display("cyc=%0d issue op=%0d src=%0d,%0d dest=%0d", cyc, op, s1, s2, d);

    // advance the model across the coming rising edge
    if (st && sc_m != 16'hFFFF) sc_m++;
    if (iss && wr && d != 0) ready_at[d] = cyc + ((op == 10) ? LD_LAT : ALU_LAT) + 1;
    case (mode)
      0: if (dr) mode = 1;
      1: if (!dr) begin mode = 0; idle_m = 1'b0; end
         else if (!any_busy) begin mode = 2; idle_m = 1'b1; end
      default: if (!dr) begin mode = 0; idle_m = 1'b0; end
    endcase
    cyc++;
  endtask

  task automatic idle_cycle();
    bit iss;
    do_cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, iss);
  endtask

  // Hold an instruction in ID until the model says it issues.
  task automatic present(input int op, input int s1, input int s2, input int d);
    bit iss;
    int n;
    n = 0;
    do begin
      do_cycle(1'b1, op, s1, s2, d, 1'b0, 1'b0, iss);
      n++;
    end while (!iss && n < 20);
    if (!iss) chk("issue_timeout", 32'(n), 32'(0));
  endtask

  // Monitor: every queued expectation is compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("stall@%0d", e.cyc), 32'(bus.stall), 32'(e.stall));
        chk($sformatf("issue@%0d", e.cyc), 32'(bus.issue), 32'(e.issue));
        chk($sformatf("busy_mask@%0d", e.cyc), 32'(busy_mask), 32'(e.busy));
        chk($sformatf("idle@%0d", e.cyc), 32'(idle), 32'(e.idle));
        chk($sformatf("stall_cycles@%0d", e.cyc), 32'(stall_cycles), 32'(e.sc));
      end
    end
  end

  initial begin
    bit iss;
    bit dr;
    int n;

    cyc = 0;
    model_reset();
    rst           = 1'b1;
    drain_req     = 1'b0;
    bus.id_valid  = 1'b1;
    bus.opcode_id = 4'd1;
    bus.src_1     = 3'd3;
    bus.src_2     = 3'd4;
    bus.dest_id   = 3'd5;
    bus.flush     = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy_mask", 32'(busy_mask), 32'(0));
    chk("rst_idle", 32'(idle), 32'(0));
    chk("rst_stall_cycles", 32'(stall_cycles), 32'(0));
    chk("rst_stall", 32'(bus.stall), 32'(0));
    chk("rst_issue", 32'(bus.issue), 32'(1));
    bus.id_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ADDI r3 then dependent ADD r4=r3+r1: three stalls
    present(9, 1, 0, 3);
    present(1, 3, 1, 4);
    idle_cycle();
    chk("dep_alu_stall_cycles", 32'(stall_cycles), 32'(3));

    // LD r2 then BZ r2: four stalls
    present(10, 1, 0, 2);
    present(12, 2, 0, 0);
    idle_cycle();
    chk("dep_ld_stall_cycles", 32'(stall_cycles), 32'(7));

    // writes to r0 never create hazards
    repeat (5) idle_cycle();
    present(9, 0, 0, 0);
    chk("r0_no_busy", 32'(busy_mask), 32'(0));
    present(1, 0, 0, 6);
    idle_cycle();
    chk("r0_no_stall", 32'(stall_cycles), 32'(7));

    // WAW: ADDI r5 then LD r5 waits, then reloads with the load latency
    repeat (5) idle_cycle();
    present(9, 0, 0, 5);
    present(10, 0, 0, 5);
    idle_cycle();
    chk("waw_busy_mask", 32'(busy_mask), 32'(8'h20));
    chk("waw_stall_cycles", 32'(stall_cycles), 32'(10));

    // flush kills a hazarding instruction
    present(9, 0, 0, 3);
    do_cycle(1'b1, 1, 3, 0, 4, 1'b1, 1'b0, iss);
    do_cycle(1'b1, 1, 3, 0, 4, 1'b1, 1'b0, iss);
    repeat (4) idle_cycle();

    // drain with a load pending, then resume
    present(10, 0, 0, 1);
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1, 2, 3, 4, 1'b0, 1'b1, iss);
    chk("drain_idle", 32'(idle), 32'(1));
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1, 2, 3, 4, 1'b0, 1'b0, iss);
    chk("resume_idle", 32'(idle), 32'(0));

    // drain requested with nothing pending
    repeat (5) idle_cycle();
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, iss);
    do_cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, iss);

    // randomized traffic
    dr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) dr = ~dr;
      do_cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0), dr, iss);
    end
    repeat (3) idle_cycle();

    // asynchronous reset in the middle of a load countdown
    present(10, 0, 0, 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_busy_mask", 32'(busy_mask), 32'(0));
    chk("async_rst_stall_cycles", 32'(stall_cycles), 32'(0));
    chk("async_rst_idle", 32'(idle), 32'(0));
    model_reset();
    bus.id_valid = 1'b0;
    bus.flush    = 1'b0;
    drain_req    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    present(9, 0, 0, 3);
    present(1, 3, 0, 2);
    repeat (2) idle_cycle();

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) chk("scoreboard_drain", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
